// File: rtl/mdu_ctrl_pkg.sv
// mdu_ctrl_pkg: shared definitions for the multiply/divide unit.
//   - md_op encodings (MD_NONE .. MD_MTLO) driven by the D/E-stage controllers
//   - default latencies for mult/multu and div/divu
//   - R-type funct codes of the HI/LO instructions, for the decoders
//   - sequencer state type and a small op-class helper
package mdu_ctrl_pkg;

  localparam logic [3:0] MD_NONE  = 4'd0;
  localparam logic [3:0] MD_MULT  = 4'd1;
  localparam logic [3:0] MD_MULTU = 4'd2;
  localparam logic [3:0] MD_DIV   = 4'd3;
  localparam logic [3:0] MD_DIVU  = 4'd4;
  localparam logic [3:0] MD_MFHI  = 4'd5;
  localparam logic [3:0] MD_MFLO  = 4'd6;
  localparam logic [3:0] MD_MTHI  = 4'd7;
  localparam logic [3:0] MD_MTLO  = 4'd8;

  localparam int MULT_CYCLES_DEF = 5;
  localparam int DIV_CYCLES_DEF  = 10;

  // funct field of the R-type HI/LO instructions
  localparam logic [5:0] FUNCT_MFHI  = 6'h10;
  localparam logic [5:0] FUNCT_MTHI  = 6'h11;
  localparam logic [5:0] FUNCT_MFLO  = 6'h12;
  localparam logic [5:0] FUNCT_MTLO  = 6'h13;
  localparam logic [5:0] FUNCT_MULT  = 6'h18;
  localparam logic [5:0] FUNCT_MULTU = 6'h19;
  localparam logic [5:0] FUNCT_DIV   = 6'h1a;
  localparam logic [5:0] FUNCT_DIVU  = 6'h1b;

  typedef enum logic {
    S_IDLE = 1'b0,
    S_RUN  = 1'b1
  } state_t;

  // Ops that occupy the unit for a fixed latency.
  function automatic logic is_arith(input logic [3:0] op);
    return (op >= MD_MULT) && (op <= MD_DIVU);
  endfunction

endpackage

// File: rtl/mdu_arith.sv
// mdu_arith: purely combinational multiply/divide datapath.
// Ports:
//   md_op    in  4   operation (only mult/multu/div/divu produce a result)
//   rs_val   in  32  rs operand (multiplicand / dividend)
//   rt_val   in  32  rt operand (multiplier / divisor)
//   result   out 64  {hi, lo}: product, or {remainder, quotient}
//   div_zero out 1   div/divu with rt_val == 0; result is then 0
module mdu_arith
  import mdu_ctrl_pkg::*;
(
  input  logic [3:0]  md_op,
  input  logic [31:0] rs_val,
  input  logic [31:0] rt_val,
  output logic [63:0] result,
  output logic        div_zero
);

  logic [63:0]        prod_s;
  logic [63:0]        prod_u;
  logic [31:0]        divisor;
  logic signed [31:0] dividend_s;
  logic signed [31:0] divisor_s;
  logic [31:0]        quot_s;
  logic [31:0]        rem_s;
  logic [31:0]        quot_u;
  logic [31:0]        rem_u;
  logic               ovf;

  // Low 64 bits of a 64x64 product of sign-extended operands are the
  // signed 32x32 product.
  assign prod_s = {{32{rs_val[31]}}, rs_val} * {{32{rt_val[31]}}, rt_val};
  assign prod_u = {32'd0, rs_val} * {32'd0, rt_val};

  assign div_zero = (rt_val == 32'd0) && ((md_op == MD_DIV) || (md_op == MD_DIVU));

  // Keep the divider away from a zero divisor; the result is discarded anyway.
  assign divisor    = (rt_val == 32'd0) ? 32'd1 : rt_val;
  assign dividend_s = rs_val;
  assign divisor_s  = divisor;

  // 0x80000000 / -1 overflows; pin it to the wrapped value with rem 0.
  assign ovf = (rs_val == 32'h8000_0000) && (rt_val == 32'hffff_ffff);

  always_comb begin
    quot_s = 32'd0;
    rem_s  = 32'd0;
    if (ovf) begin
      quot_s = 32'h8000_0000;
      rem_s  = 32'd0;
    end else begin
      quot_s = dividend_s / divisor_s;
      rem_s  = dividend_s % divisor_s;
    end
  end

  assign quot_u = rs_val / divisor;
  assign rem_u  = rs_val % divisor;

  always_comb begin
    result = 64'd0;
    case (md_op)
      MD_MULT:  result = prod_s;
      MD_MULTU: result = prod_u;
      MD_DIV:   result = div_zero ? 64'd0 : {rem_s, quot_s};
      MD_DIVU:  result = div_zero ? 64'd0 : {rem_u, quot_u};
      default:  result = 64'd0;
    endcase
  end

endmodule

// File: rtl/mdu_ctrl.sv
// mdu_ctrl: multi-cycle multiply/divide sequencer owning HI/LO.
// Ports:
//   clk, reset        clock; asynchronous active-high reset
//   start, md_op      E-stage mdu op valid this cycle and its encoding
//   rs_val, rt_val    forwarded E-stage operands
//   d_is_md           D-stage instruction is any mdu op
//   busy              a mult/div latency is being counted
//   stall_md          hold the D-stage mdu instruction
//   hi_out, lo_out    architectural HI/LO
//   md_rd             mfhi/mflo read data (0 for other ops)
// Handshake: start is a single-cycle issue strobe with no ready return;
// it is honoured only while busy is low. The hazard unit keeps every mdu op
// in D (stall_md) until the unit can take it, so an issue never meets busy.
// The result is computed at issue and parked in pend_hi/pend_lo; HI/LO only
// change on the edge where the counter reaches zero.
module mdu_ctrl
  import mdu_ctrl_pkg::*;
#(
  parameter int MULT_CYCLES = MULT_CYCLES_DEF,
  parameter int DIV_CYCLES  = DIV_CYCLES_DEF
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [3:0]  md_op,
  input  logic [31:0] rs_val,
  input  logic [31:0] rt_val,
  input  logic        d_is_md,
  output logic        busy,
  output logic        stall_md,
  output logic [31:0] hi_out,
  output logic [31:0] lo_out,
  output logic [31:0] md_rd
);

  localparam int MAX_CYCLES = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
  localparam int CNT_W      = $clog2(MAX_CYCLES + 1);

  logic [CNT_W-1:0] cnt, cnt_next;
  logic [31:0]      hi, hi_next;
  logic [31:0]      lo, lo_next;
  logic [31:0]      pend_hi, pend_hi_next;
  logic [31:0]      pend_lo, pend_lo_next;
  logic [63:0]      arith_res;
  logic             div_zero;

  // Sequencer state, derived from the counter and exposed for checkers.
  state_t state;
  assign state = (cnt != '0) ? S_RUN : S_IDLE;

  mdu_arith u_arith (
    .md_op    (md_op),
    .rs_val   (rs_val),
    .rt_val   (rt_val),
    .result   (arith_res),
    .div_zero (div_zero)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt     <= '0;
      hi      <= 32'd0;
      lo      <= 32'd0;
      pend_hi <= 32'd0;
      pend_lo <= 32'd0;
    end else begin
      cnt     <= cnt_next;
      hi      <= hi_next;
      lo      <= lo_next;
      pend_hi <= pend_hi_next;
      pend_lo <= pend_lo_next;
    end
  end

  always_comb begin
    cnt_next     = cnt;
    hi_next      = hi;
    lo_next      = lo;
    pend_hi_next = pend_hi;
    pend_lo_next = pend_lo;
    case (state)
      S_IDLE: begin
        if (start) begin
          if (is_arith(md_op)) begin
            // Divide by zero parks the current HI/LO so the final write
            // leaves them unchanged while the full latency still runs.
            if (div_zero) begin
              pend_hi_next = hi;
              pend_lo_next = lo;
            end else begin
              pend_hi_next = arith_res[63:32];
              pend_lo_next = arith_res[31:0];
            end
            cnt_next = ((md_op == MD_MULT) || (md_op == MD_MULTU))
                       ? CNT_W'(MULT_CYCLES) : CNT_W'(DIV_CYCLES);
          end else if (md_op == MD_MTHI) begin
            hi_next = rs_val;
          end else if (md_op == MD_MTLO) begin
            lo_next = rs_val;
          end
        end
      end
      S_RUN: begin
        // Any start seen here is dropped.
        cnt_next = cnt - 1'b1;
        if (cnt == CNT_W'(1)) begin
          hi_next = pend_hi;
          lo_next = pend_lo;
        end
      end
      default: cnt_next = '0;
    endcase
  end

  assign busy     = (state == S_RUN);
  assign stall_md = d_is_md && (busy || (start && is_arith(md_op)));
  assign hi_out   = hi;
  assign lo_out   = lo;
  assign md_rd    = (md_op == MD_MFHI) ? hi :
                    (md_op == MD_MFLO) ? lo : 32'd0;

endmodule
